// File: rtl/output_transfer_if.sv
// Output-transfer bus: the flush request/ack pair, the output-buffer read
// port and the result stream, grouped as one bundle.
// Optional macro XNOR_OUT_LAST_EN adds out_last_o (last-beat marker).
// The master modport is the transfer engine, which drives the read port
// and the stream. The slave modport is its surroundings: the flush FSM,
// the buffer and the stream sink.
interface output_transfer_if #(
    parameter int TPO       = 8,
    parameter int DataWidth = 32
);
    localparam int AddrWidth = (TPO > 1) ? $clog2(TPO) : 1;

    logic                 transfer_req_i;
    logic                 transfer_ack_o;
    logic                 rd_en_o;
    logic [AddrWidth-1:0] rd_addr_o;
    logic [DataWidth-1:0] rd_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DataWidth-1:0] out_data_o;
    logic                 busy_o;
`ifdef XNOR_OUT_LAST_EN
    logic                 out_last_o;
`endif

    modport master (
        input  transfer_req_i,
        input  rd_data_i,
        input  out_ready_i,
        output transfer_ack_o,
        output rd_en_o,
        output rd_addr_o,
        output out_valid_o,
        output out_data_o,
        output busy_o
`ifdef XNOR_OUT_LAST_EN
        , output out_last_o
`endif
    );

    modport slave (
        output transfer_req_i,
        output rd_data_i,
        output out_ready_i,
        input  transfer_ack_o,
        input  rd_en_o,
        input  rd_addr_o,
        input  out_valid_o,
        input  out_data_o,
        input  busy_o
`ifdef XNOR_OUT_LAST_EN
        , input out_last_o
`endif
    );
endinterface

// File: rtl/output_transfer_fsm.sv
// Output-transfer responder. On a request from the flush FSM it reads TPO
// output-buffer entries in address order, streams them on a valid/ready
// port through a 2-entry FIFO, pulses transfer_ack_o after the last beat
// is accepted, and then waits for the request to drop before re-arming.
// Optional macro XNOR_OUT_LAST_EN drives out_last_o on the final beat.
module output_transfer_fsm #(
    parameter int TPO       = 8,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output_transfer_if.master    bus
);
    localparam int          AddrWidth = (TPO > 1) ? $clog2(TPO) : 1;
    localparam logic [31:0] TpoCnt    = 32'(TPO);
    localparam logic [31:0] LastBeat  = 32'(TPO - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StAck,
        StRelease
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [31:0]          rd_cnt;      // reads issued in this transfer
    logic [31:0]          beat_cnt;    // beats accepted in this transfer
    logic                 inflight;    // read issued last cycle, data on rd_data_i now

    logic [DataWidth-1:0] fifo_mem [2];
    logic                 fifo_wr_ptr;
    logic                 fifo_rd_ptr;
    logic [1:0]           fifo_count;

    logic                 out_valid;
    logic                 push;
    logic                 pop;
    logic [2:0]           occupancy;   // slots still held after this cycle's pop
    logic                 start;
    logic                 rd_en;
    logic                 ack;
    logic                 busy;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && bus.out_ready_i;
    assign push      = inflight;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes derived from the current state.
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_next = state;
        start      = 1'b0;
        rd_en      = 1'b0;
        ack        = 1'b0;
        busy       = 1'b1;
        unique case (state)
            StIdle: begin
                busy = 1'b0;
                if (bus.transfer_req_i) begin
                    start      = 1'b1;
                    state_next = StRead;
                end
            end
            StRead: begin
                // Issue only while the FIFO plus the in-flight read leave a
                // free slot for the data coming back next cycle.
                if (rd_cnt < TpoCnt) begin
                    rd_en = (occupancy <= 3'd1);
                end else begin
                    state_next = StDrain;
                end
            end
            StDrain: begin
                if (pop && (beat_cnt == LastBeat)) begin
                    state_next = StAck;
                end
            end
            StAck: begin
                ack        = 1'b1;
                state_next = StRelease;
            end
            StRelease: begin
                // A request still high here belongs to the finished transfer.
                if (!bus.transfer_req_i) begin
                    state_next = StIdle;
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // Read and beat counters plus the in-flight marker for the read port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (start) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (rd_en) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + 32'd1;
                end
            end
        end
    end

    // Two-entry output FIFO; read data lands here one cycle after its strobe.
    // A push and a pop in the same cycle are allowed even when full: the
    // write targets the slot being vacated by the pop.
    // NOTE: the two storage words are reset as well, so out_data_o reads 0
    // out of reset rather than whatever the flops powered up with.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= bus.rd_data_i;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.transfer_ack_o = ack;
    assign bus.busy_o         = busy;
    assign bus.rd_en_o        = rd_en;
    assign bus.rd_addr_o      = rd_cnt[AddrWidth-1:0];
    assign bus.out_valid_o    = out_valid;
    assign bus.out_data_o     = fifo_mem[fifo_rd_ptr];

`ifdef XNOR_OUT_LAST_EN
    // Beats leave in order, so the head is beat number beat_cnt.
    assign bus.out_last_o = out_valid && (beat_cnt == LastBeat);
`endif

endmodule

// File: tb/tb_output_transfer_fsm.sv
// Scoreboard bench for output_transfer_fsm. The stimulus thread pushes the
// expected read addresses, beats and acks into queues; an independent
// monitor pops and compares them as the DUT presents them.
module tb_output_transfer_fsm;
    localparam int TPO       = 8;
    localparam int DataWidth = 32;
    localparam int AddrWidth = (TPO > 1) ? $clog2(TPO) : 1;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    logic [DataWidth-1:0] mem [TPO];
    logic [DataWidth-1:0] exp_q[$];
    logic [AddrWidth-1:0] exp_addr_q[$];
    bit                   ack_q[$];

    output_transfer_if #(.TPO(TPO), .DataWidth(DataWidth)) bus ();

    output_transfer_fsm #(.TPO(TPO), .DataWidth(DataWidth)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-buffer model: data for a strobed address appears one cycle
    // later; otherwise the bus carries junk.
    always @(posedge clk) begin
        bus.rd_data_i <= bus.rd_en_o ? mem[bus.rd_addr_o] : DataWidth'($urandom());
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int                   issued;
    int                   accepted;
    int                   beat_idx;
    int                   last_accept_cyc;
    bit                   prev_stall;
    bit                   prev_ack;
    logic [DataWidth-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            issued     = 0;
            accepted   = 0;
            beat_idx   = 0;
            prev_stall = 0;
            prev_ack   = 0;
        end else begin
            automatic bit pop = bus.out_valid_o && bus.out_ready_i;
            if (bus.rd_en_o) begin
                if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
                else check("rd_addr", 64'(bus.rd_addr_o), 64'(exp_addr_q.pop_front()));
                // After this read lands, at most 2 entries may be held.
                check("buffered_max2", 64'((issued + 1 - accepted - int'(pop)) <= 2), 1);
            end
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.out_valid_o), 1);
                check("stall_data_held", 64'(bus.out_data_o), 64'(prev_data));
            end
`ifdef XNOR_OUT_LAST_EN
            if (bus.out_valid_o) check("out_last", 64'(bus.out_last_o), 64'(beat_idx == TPO - 1));
`endif
            if (pop) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("beat_data", 64'(bus.out_data_o), 64'(exp_q.pop_front()));
                beat_idx++;
                last_accept_cyc = cyc;
            end
            if (bus.transfer_ack_o) begin
                if (ack_q.size() == 0) check("unexpected_ack", 1, 0);
                else void'(ack_q.pop_front());
                check("ack_single_pulse", 64'(prev_ack), 0);
                check("ack_after_last_beat", 64'(cyc), 64'(last_accept_cyc + 1));
                check("beats_per_ack", 64'(beat_idx), 64'(TPO));
                beat_idx = 0;
            end
            issued    += int'(bus.rd_en_o);
            accepted  += int'(pop);
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_data  = bus.out_data_o;
            prev_ack   = bus.transfer_ack_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill the buffer and queue everything one transfer should produce.
    task automatic load(input bit counting);
        for (int i = 0; i < TPO; i++) begin
            mem[i] = counting ? DataWidth'(32'hA0 + i) : DataWidth'($urandom());
            exp_q.push_back(mem[i]);
            exp_addr_q.push_back(AddrWidth'(i));
        end
        ack_q.push_back(1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"},   64'(bus.transfer_ack_o), 0);
        check({name, "_rd_en"}, 64'(bus.rd_en_o), 0);
        check({name, "_addr"},  64'(bus.rd_addr_o), 0);
        check({name, "_valid"}, 64'(bus.out_valid_o), 0);
        check({name, "_data"},  64'(bus.out_data_o), 0);
        check({name, "_busy"},  64'(bus.busy_o), 0);
`ifdef XNOR_OUT_LAST_EN
        check({name, "_last"},  64'(bus.out_last_o), 0);
`endif
    endtask

    // mode 0: ready always high; 1: toggles 1,0,1,0; 2: random.
    task automatic run_transfer(input int mode, input int hold);
        bit got_ack;
        load(1'b0);
        got_ack = 0;
        for (int i = 0; i < 400 && !got_ack; i++) begin
            step();
            bus.transfer_req_i = 1'b1;
            bus.out_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            got_ack = bus.transfer_ack_o;
        end
        if (!got_ack) check("ack_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            step();
            @(negedge clk);
            check("release_busy", 64'(bus.busy_o), 1);
            check("release_no_read", 64'(bus.rd_en_o), 0);
        end
        step();
        bus.transfer_req_i = 1'b0;
        @(negedge clk);
        check("release_busy_at_drop", 64'(bus.busy_o), 1);
        step();
        @(negedge clk);
        check("idle_after_drop", 64'(bus.busy_o), 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.transfer_req_i = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Cycle-exact latency with ready held high.
        load(1'b1);
        for (int k = 0; k <= TPO + 5; k++) begin
            step();
            if (k == 0) begin
                bus.transfer_req_i = 1'b1;
                bus.out_ready_i = 1'b1;
            end
            if (k == TPO + 4) bus.transfer_req_i = 1'b0;
            @(negedge clk);
            check("lat_rd_en", 64'(bus.rd_en_o), 64'(k >= 1 && k <= TPO));
            check("lat_valid", 64'(bus.out_valid_o), 64'(k >= 3 && k <= TPO + 2));
            if (k >= 3 && k <= TPO + 2) check("lat_data", 64'(bus.out_data_o), 64'(32'hA0 + k - 3));
            check("lat_ack", 64'(bus.transfer_ack_o), 64'(k == TPO + 3));
            check("lat_busy", 64'(bus.busy_o), 64'(k >= 1 && k <= TPO + 4));
`ifdef XNOR_OUT_LAST_EN
            check("lat_last", 64'(bus.out_last_o), 64'(k == TPO + 2));
`endif
        end

        run_transfer(0, 0);
        run_transfer(1, 0);
        for (int t = 0; t < 4; t++) run_transfer(2, 0);

        // Long stall from cycle 2: only two reads may go out, then one beat
        // per cycle once ready returns at cycle 22.
        begin
            int reads;
            reads = 0;
            load(1'b0);
            for (int k = 0; k <= 32; k++) begin
                step();
                if (k == 0) bus.transfer_req_i = 1'b1;
                if (k == 31) bus.transfer_req_i = 1'b0;
                bus.out_ready_i = (k < 2 || k >= 22);
                @(negedge clk);
                if (k <= 21) reads += int'(bus.rd_en_o);
                if (k == 21) check("stall_reads", 64'(reads), 2);
                if (k >= 22 && k <= 29) check("stall_flow", 64'(bus.out_valid_o && bus.out_ready_i), 1);
                if (k == 30) check("stall_ack", 64'(bus.transfer_ack_o), 1);
                if (k == 32) check("stall_idle", 64'(bus.busy_o), 0);
            end
        end

        // Request held 5 cycles past the ack, then a fresh request.
        run_transfer(0, 5);
        run_transfer(0, 0);

        // Reset in cycle 6 of a transfer.
        load(1'b0);
        for (int k = 0; k <= 5; k++) begin
            step();
            bus.transfer_req_i = 1'b1;
            bus.out_ready_i = 1'b1;
        end
        step();
        rst_n = 1'b0;
        bus.transfer_req_i = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        ack_q.delete();
        #1;
        check_all_zero("abort");
        repeat (2) step();
        rst_n = 1'b1;
        run_transfer(2, 0);

        repeat (5) step();
        check("left_beats", 64'(exp_q.size()), 0);
        check("left_reads", 64'(exp_addr_q.size()), 0);
        check("left_acks", 64'(ack_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
